fpdiv_iter: RTL and testbench
=============================

FPDIV_ITER -- requirements
Module: fpdiv_iter

Interface
REQ-001 Parameters (name, default, meaning): EXP_W, 8, exponent width; MAN_W, 23, stored fraction width. Operand width W = 1+EXP_W+MAN_W.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  W  dividend, IEEE-754-style packing.
REQ-007 b  input  W  divisor.
REQ-008 rm  input  1  rounding mode: 0 = round-nearest-even, 1 = round-toward-zero.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  W  quotient a/b.
REQ-012 flags  output  5  {invalid, divzero, overflow, underflow, inexact}.

Function
REQ-013 Transfer on input (output) side occurs when valid and ready are both high at a rising edge.
REQ-014 FSM states: IDLE, UNPACK, DIVIDE, ROUND, DONE; in_ready is high only in IDLE.
REQ-015 IDLE -> UNPACK on input transfer; a, b and rm are captured then; later input changes are ignored.
REQ-016 UNPACK (1 cycle): classify operands; subnormal inputs flushed to signed zero; special case -> DONE, else -> DIVIDE.
REQ-017 Special cases: NaN operand, 0/0 or inf/inf -> canonical qNaN (exp all ones, fraction MSB 1, sign 0), invalid; finite nonzero/0 -> signed inf, divzero; inf/finite -> signed inf; finite/inf or 0/nonzero -> signed zero; no other flags.
REQ-018 DIVIDE: radix-2 restoring division of {1,frac_a} by {1,frac_b}, one quotient bit per cycle, MAN_W+3 cycles, final remainder nonzero forms sticky bit; iteration counter counts down to 0 then -> ROUND.
REQ-019 Result sign = sign_a XOR sign_b; unbiased exponent = exp_a - exp_b + bias, held EXP_W+2 bits signed; normalise by one left shift (exp-1) when quotient MSB is 0.
REQ-020 ROUND (1 cycle): apply rm using guard, round, sticky; mantissa carry-out increments exponent; inexact = any discarded bit nonzero.
REQ-021 Exponent >= all-ones after rounding -> overflow+inexact; RNE returns signed inf, RTZ returns signed max finite.
REQ-022 Exponent <= 0 -> signed zero, underflow+inexact (flush-to-zero output, no subnormals).
REQ-023 DONE: out_valid high, result/flags stable until output transfer, then -> IDLE; out_ready low holds indefinitely.
REQ-024 Latency from input transfer to out_valid: normal MAN_W+5 cycles (28 at defaults), special case 2 cycles; one operation in flight, no pipelining.
REQ-025 Signed-zero divisor of nonzero finite: sign rule of REQ-019 applies to the inf.

Reset
REQ-026 rst_n low at any time, including mid-DIVIDE or DONE, immediately forces IDLE, in_ready=1 after release, out_valid=0, result=0, flags=0, counter=0; in-flight operation discarded, no output produced.

Structure
REQ-027 Shared package fpdiv_pkg holds FSM state enum, flag bit index constants, operand class enum and canonical-NaN function of EXP_W/MAN_W.
REQ-028 One sub-module, fpdiv_round: combinational rounding/overflow/underflow packing, reused by future FP units.

Verification
REQ-029 0x40C00000 / 0x40000000, rm=0 -> 0x40400000, flags 0, out_valid 28 cycles after accept.
REQ-030 0x3F800000 / 0x40400000: rm=0 -> 0x3EAAAAAB, rm=1 -> 0x3EAAAAAA, inexact set.
REQ-031 0x3F800000 / 0x00000000 -> 0x7F800000 divzero; 0x00000000 / 0x00000000 -> 0x7FC00000 invalid; each after 2 cycles.
REQ-032 0x7F000000 / 0x3E800000: rm=0 -> 0x7F800000, rm=1 -> 0x7F7FFFFF, overflow+inexact; 0x00800000 / 0x40000000 -> 0x00000000 underflow+inexact.
REQ-033 out_ready low 10 cycles after out_valid -> result stable, in_ready 0, new in_valid ignored; then out_ready high -> one transfer, IDLE.
REQ-034 rst_n pulsed low during DIVIDE -> out_valid 0, no result emitted; next operation 0x40C00000/0x40000000 -> 0x40400000.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// ============================================================================
//  fpdiv_pkg : shared types and constants for the iterative FP divider
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package fpdiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_DIVIDE = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    localparam int FLAGS_W       = 5;
    localparam int FLG_INVALID   = 4;
    localparam int FLG_DIVZERO   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // Positive quiet NaN: exponent all ones, fraction MSB set; caller truncates.
    function automatic logic [127:0] canon_nan(input int exp_w, input int man_w);
        logic [127:0] r;
        r = ((128'd1 << exp_w) - 128'd1) << man_w;
        r = r | (128'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpdiv_round.sv
// ============================================================================
//  fpdiv_round : combinational rounding, overflow and flush-to-zero packing
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fpdiv_round
    import fpdiv_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   sign_i,
    input  logic [EXP_W+1:0]       exp_i,
    input  logic [MAN_W:0]         mant_i,
    input  logic                   guard_i,
    input  logic                   round_i,
    input  logic                   sticky_i,
    input  logic                   rm_i,
    output logic [EXP_W+MAN_W:0]   result_o,
    output logic [2:0]             flags_o
);

    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0]    EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    logic               w_inexact;
    logic               w_inc;
    logic [MAN_W+1:0]   w_sum;
    logic [MAN_W-1:0]   w_frac;
    logic [EW-1:0]      w_exp;
    logic               w_over;
    logic               w_under;

    always_comb begin
        w_inexact = guard_i | round_i | sticky_i;
        w_inc     = ~rm_i & guard_i & (round_i | sticky_i | mant_i[0]);
        w_sum     = {1'b0, mant_i} + (MAN_W + 2)'(w_inc);

        if (w_sum[MAN_W+1]) begin
            w_frac = w_sum[MAN_W:1];
        end else begin
            w_frac = w_sum[MAN_W-1:0];
        end
        w_exp = exp_i + EW'(w_sum[MAN_W+1]);

        // Exponent is two's complement; test the sign bit before magnitude.
        w_over  = ~w_exp[EW-1] & (w_exp >= EXP_MAX);
        w_under = w_exp[EW-1] | (w_exp == '0);

        flags_o = '0;
        if (w_over) begin
            result_o = rm_i ? {sign_i, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}}
                            : {sign_i, EXP_ONES, {MAN_W{1'b0}}};
            flags_o[FLG_OVERFLOW] = 1'b1;
            flags_o[FLG_INEXACT]  = 1'b1;
        end else if (w_under) begin
            result_o = {sign_i, {(EXP_W + MAN_W){1'b0}}};
            flags_o[FLG_UNDERFLOW] = 1'b1;
            flags_o[FLG_INEXACT]   = 1'b1;
        end else begin
            result_o = {sign_i, w_exp[EXP_W-1:0], w_frac};
            flags_o[FLG_INEXACT] = w_inexact;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpdiv_iter.sv
// ============================================================================
//  fpdiv_iter : iterative radix-2 restoring floating-point divider
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module fpdiv_iter
    import fpdiv_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [FLAGS_W-1:0]     flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 3);
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAN_W + 2);
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]     QNAN     = W'(canon_nan(EXP_W, MAN_W));

    state_e             state_q;
    logic [W-1:0]       a_q, b_q;
    logic               rm_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MAN_W+1:0]   rem_q;
    logic [MAN_W:0]     div_q;
    logic [MAN_W+2:0]   quo_q;
    logic               sign_q;
    logic [EW-1:0]      exp_q;
    logic               special_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [W-1:0]       result_q;
    logic [FLAGS_W-1:0] flags_q;

    function automatic cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)            return CLS_ZERO;
        else if (e != EXP_ONES) return CLS_NORM;
        else if (f == '0)       return CLS_INF;
        else                    return CLS_NAN;
    endfunction

    logic               w_sa, w_sb;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_fa, w_fb;
    cls_e               w_ca, w_cb;
    logic               w_sign;
    logic [EW-1:0]      w_exp_diff;

    assign {w_sa, w_ea, w_fa} = a_q;
    assign {w_sb, w_eb, w_fb} = b_q;
    assign w_ca       = classify(w_ea, w_fa);
    assign w_cb       = classify(w_eb, w_fb);
    assign w_sign     = w_sa ^ w_sb;
    assign w_exp_diff = EW'(w_ea) - EW'(w_eb) + EW'(BIAS);

    logic               w_special;
    logic [W-1:0]       w_spec_res;
    logic [FLAGS_W-1:0] w_spec_flags;

    // Subnormals already classify as zero, so they follow the zero rows.
    always_comb begin
        w_special    = 1'b1;
        w_spec_res   = '0;
        w_spec_flags = '0;
        if ((w_ca == CLS_NAN) || (w_cb == CLS_NAN) ||
            ((w_ca == CLS_ZERO) && (w_cb == CLS_ZERO)) ||
            ((w_ca == CLS_INF) && (w_cb == CLS_INF))) begin
            w_spec_res                = QNAN;
            w_spec_flags[FLG_INVALID] = 1'b1;
        end else if ((w_ca == CLS_NORM) && (w_cb == CLS_ZERO)) begin
            w_spec_res                = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_spec_flags[FLG_DIVZERO] = 1'b1;
        end else if (w_ca == CLS_INF) begin
            w_spec_res = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if ((w_cb == CLS_INF) || (w_ca == CLS_ZERO)) begin
            w_spec_res = {w_sign, {(W - 1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    logic [MAN_W+1:0]   w_diff;
    logic               w_borrow;
    logic               w_qbit;
    logic [MAN_W+1:0]   w_rem_nxt;

    assign {w_borrow, w_diff} = {1'b0, rem_q} - {2'b00, div_q};
    assign w_qbit    = ~w_borrow;
    assign w_rem_nxt = (w_qbit ? w_diff : rem_q) << 1;

    // Quotient lies in (0.5, 2): a clear MSB means one bit of left normalisation.
    logic               w_norm;
    logic [MAN_W:0]     w_mant;
    logic               w_guard;
    logic               w_round;
    logic [EW-1:0]      w_exp_n;
    logic [W-1:0]       w_rnd_res;
    logic [2:0]         w_rnd_flags;

    assign w_norm  = quo_q[MAN_W+2];
    assign w_mant  = w_norm ? quo_q[MAN_W+2:2] : quo_q[MAN_W+1:1];
    assign w_guard = w_norm ? quo_q[1] : quo_q[0];
    assign w_round = w_norm ? quo_q[0] : 1'b0;
    assign w_exp_n = w_norm ? exp_q : exp_q - EW'(1);

    fpdiv_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign_i   (sign_q),
        .exp_i    (w_exp_n),
        .mant_i   (w_mant),
        .guard_i  (w_guard),
        .round_i  (w_round),
        .sticky_i (|rem_q),
        .rm_i     (rm_q),
        .result_o (w_rnd_res),
        .flags_o  (w_rnd_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rm_q        <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            special_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        rm_q       <= rm;
                        in_ready_q <= 1'b0;
                        state_q    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    special_q <= w_special;
                    sign_q    <= w_sign;
                    exp_q     <= w_exp_diff;
                    rem_q     <= {2'b01, w_fa};
                    div_q     <= {1'b1, w_fb};
                    quo_q     <= '0;
                    cnt_q     <= CNT_LOAD;
                    // Specials hop through ROUND (untouched there) for a fixed 2-cycle latency.
                    if (w_special) begin
                        result_q <= w_spec_res;
                        flags_q  <= w_spec_flags;
                        state_q  <= S_ROUND;
                    end else begin
                        state_q  <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= w_rem_nxt;
                    quo_q <= {quo_q[MAN_W+1:0], w_qbit};
                    if (cnt_q == '0) begin
                        state_q <= S_ROUND;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_ROUND: begin
                    if (!special_q) begin
                        result_q <= w_rnd_res;
                        flags_q  <= {2'b00, w_rnd_flags};
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_fpdiv_iter.sv
// ============================================================================
//  tb_fpdiv_iter : randomized and directed checks of fpdiv_iter (binary32)
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fpdiv_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;

    int total = 0;
    int bad   = 0;

    fpdiv_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Reference: exact integer quotient scaled by 2^26, then IEEE rounding by value.
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic trm,
                                    output logic [31:0] r, output logic [4:0] f, output int lat);
        int ex, ey, e, k;
        bit xz, yz, xinf, yinf, xnan, ynan, up, inexact;
        logic s;
        longint mx, my, q, rem, mant, d, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xinf = (ex == 255) && (x[22:0] == 0);
        yinf = (ey == 255) && (y[22:0] == 0);
        xnan = (ex == 255) && (x[22:0] != 0);
        ynan = (ey == 255) && (y[22:0] != 0);
        lat = 2;
        f = 5'b00000;
        if (xnan || ynan || (xz && yz) || (xinf && yinf)) begin
            r = 32'h7FC00000; f = 5'b10000;
        end else if (yz && !xinf) begin
            r = {s, 8'hFF, 23'h0}; f = 5'b01000;
        end else if (xinf) begin
            r = {s, 8'hFF, 23'h0};
        end else if (yinf || xz) begin
            r = {s, 31'h0};
        end else begin
            lat = 28;
            mx = longint'({1'b1, x[22:0]});
            my = longint'({1'b1, y[22:0]});
            q = (mx << 26) / my;
            rem = (mx << 26) % my;
            e = ex - ey + 127;
            if (q >= (longint'(1) << 26)) k = 3;
            else begin k = 2; e = e - 1; end
            mant = q >> k;
            d = q & ((longint'(1) << k) - 1);
            half = longint'(1) << (k - 1);
            inexact = (d != 0) || (rem != 0);
            up = !trm && ((d > half) || ((d == half) && ((rem != 0) || ((mant & 1) != 0))));
            if (up) mant = mant + 1;
            if (mant == (longint'(1) << 24)) begin
                mant = longint'(1) << 23;
                e = e + 1;
            end
            if (e >= 255) begin
                r = trm ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
                f = 5'b00101;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 5'b00011;
            end else begin
                r = {s, e[7:0], mant[22:0]};
                f = {4'b0000, inexact};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int sel;
        v = $urandom;
        sel = $urandom_range(0, 19);
        case (sel)
            0:       v[30:0] = 31'h0;
            1:       v[30:0] = {8'hFF, 23'h0};
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'h00;
            4, 5, 6: v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Issue one operation, time accept->out_valid in cycles, then drain it.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic trm,
                          output logic [31:0] r, output logic [4:0] f, output int lat);
        int n;
        @(negedge clk);
        a = xa; b = xb; rm = trm; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; rm = ~trm;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        f = flags;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++;
        if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        total++;
        if (flags !== 5'h0) begin bad++; $display("FAIL reset_flags: got %b want 00000", flags); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] va [8] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                32'h00000000, 32'h7F000000, 32'h7F000000, 32'h00800000};
        logic [31:0] vb [8] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
                                32'h00000000, 32'h3E800000, 32'h3E800000, 32'h40000000};
        logic        vr [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ve [8] = '{32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 32'h7F800000,
                                32'h7FC00000, 32'h7F800000, 32'h7F7FFFFF, 32'h00000000};
        logic [4:0]  vf [8] = '{5'b00000, 5'b00001, 5'b00001, 5'b01000,
                                5'b10000, 5'b00101, 5'b00101, 5'b00011};
        int          vl [8] = '{28, 28, 28, 2, 2, 28, 28, 28};
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], vr[i], r, f, lat);
            total++;
            if (r !== ve[i]) begin bad++; $display("FAIL directed%0d_result: got %h want %h", i, r, ve[i]); end
            total++;
            if (f !== vf[i]) begin bad++; $display("FAIL directed%0d_flags: got %b want %b", i, f, vf[i]); end
            total++;
            if (lat != vl[i]) begin bad++; $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, vl[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] xa, xb, r, er;
        logic [4:0]  f, ef;
        logic        trm;
        int          lat, elat;
        for (int i = 0; i < 60; i++) begin
            xa = rand_op();
            xb = rand_op();
            trm = 1'($urandom_range(0, 1));
            ref_div(xa, xb, trm, er, ef, elat);
            run_op(xa, xb, trm, r, f, lat);
            total++;
            if (r !== er) begin bad++; $display("FAIL random%0d_result: %h/%h rm=%b got %h want %h", i, xa, xb, trm, r, er); end
            total++;
            if (f !== ef) begin bad++; $display("FAIL random%0d_flags: %h/%h rm=%b got %b want %b", i, xa, xb, trm, f, ef); end
            total++;
            if (lat != elat) begin bad++; $display("FAIL random%0d_latency: got %0d want %0d", i, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; rm = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!out_valid) begin bad++; $display("FAIL bp_wait_valid: got %b want 1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = $urandom; b = $urandom; rm = 1'b1;
            @(posedge clk);
            #1;
            total++;
            if (result !== 32'h40400000 || flags !== 5'h0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: got res=%h flags=%b ov=%b ir=%b want 40400000 00000 1 0",
                         i, result, flags, out_valid, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_no_second: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [4:0]  f;
        int          lat, seen;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; rm = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || flags !== 5'h0) begin
            bad++;
            $display("FAIL midreset_state: got ov=%b ir=%b res=%h flags=%b want 0 1 00000000 00000",
                     out_valid, in_ready, result, flags);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL midreset_no_output: got %0d valid cycles want 0", seen); end
        run_op(32'h40C00000, 32'h40000000, 1'b0, r, f, lat);
        total++;
        if (r !== 32'h40400000 || f !== 5'h0) begin
            bad++; $display("FAIL midreset_next_op: got %h %b want 40400000 00000", r, f);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        rm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
